// File: rtl/sigmoid_pkg.sv
// Shared constants and the result record for the sigmoid lookup arbiter.
// Q8.8 operands are looked up in a 97-entry Q0.8 table covering |x| in [0, 6].
package sigmoid_pkg;

  localparam int ROM_MAX_ADDR = 96;
  localparam int ADDR_SHIFT   = 4;
  localparam int ONE_Q8       = 256;
  localparam int ROM_AW       = 7;
  localparam int Y_W          = 16;
  localparam int ID_MAX_W     = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [Y_W-1:0]      y;
  } result_t;

  // The table only covers x >= 0; sigmoid(-x) = 1 - sigmoid(x).
  function automatic logic [Y_W-1:0] fold_sigmoid(input logic sign, input logic [7:0] p);
    logic [Y_W-1:0] w;
    w = {8'd0, p};
    if (sign) begin
      fold_sigmoid = Y_W'(ONE_Q8) - w;
    end else begin
      fold_sigmoid = w;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the
// last one granted; the pointer only moves when i_adv is high and a grant is issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_adv,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  // Priority search starting at r_ptr, wrapping around.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer moves past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && w_found) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// N-way round-robin front end sharing one external sigmoid table through a
// two-stage pipeline (S1 lookup address, S2 registered result) with backpressure.
module sigmoid_arbiter
  import sigmoid_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*X_W-1:0]     req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [6:0]               rom_addr,
  input  logic [15:0]              rom_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [15:0]              resp_y
);

  localparam int IW = $clog2(N_REQ);

  logic                  w_stall;
  logic                  w_accept;
  logic [N_REQ-1:0]      w_grant;
  logic [IW-1:0]         w_idx;
  logic [X_W-1:0]        w_x;
  logic [X_W-1:0]        w_mag;
  logic [X_W-1:0]        w_shift;
  logic [ROM_AW-1:0]     w_addr;
  logic [ID_MAX_W+7:0]   w_unused;

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic [IW-1:0]         r_s1_id;
  logic [ROM_AW-1:0]     r_rom_addr;
  logic                  r_resp_valid;
  result_t               r_result;

  assign w_stall = r_resp_valid & ~resp_ready;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid & {N_REQ{~w_stall}}),
    .i_adv   (~w_stall),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grants are suppressed while reset is asserted.
  assign req_ready = w_grant & {N_REQ{rst_n}};
  assign w_accept  = |req_ready;

  // Operand select, magnitude and saturated table address; -32768 folds to 0x8000.
  always_comb begin
    w_x = req_x[int'(w_idx)*X_W +: X_W];
    if (w_x[X_W-1]) begin
      w_mag = ~w_x + X_W'(1);
    end else begin
      w_mag = w_x;
    end
    w_shift = w_mag >> ADDR_SHIFT;
    if (w_shift > X_W'(ROM_MAX_ADDR)) begin
      w_addr = ROM_AW'(ROM_MAX_ADDR);
    end else begin
      w_addr = w_shift[ROM_AW-1:0];
    end
  end

  // S1: capture the winner; rom_addr holds when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_id    <= '0;
      r_rom_addr <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sign  <= w_x[X_W-1];
        r_s1_id    <= w_idx;
        r_rom_addr <= w_addr;
      end
    end
  end

  // S2: registered result, frozen while the consumer holds off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_result     <= '0;
    end else if (!w_stall) begin
      r_resp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result.id <= ID_MAX_W'(r_s1_id);
        r_result.y  <= fold_sigmoid(r_s1_sign, rom_data[7:0]);
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_result.id[IW-1:0];
  assign resp_y     = r_result.y;
  assign w_unused   = {rom_data[15:8], r_result.id};

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter: table vectors for single lookups plus
// hand-written round-robin, backpressure and mid-flight reset sequences.
module tb_sigmoid_arbiter;

  localparam int N  = 4;
  localparam int XW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]    req_ready;
  logic [6:0]      rom_addr;
  logic [15:0]     rom_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [15:0]     resp_y;

  logic [15:0] rom_tbl [128];
  assign rom_data = rom_tbl[rom_addr];

  sigmoid_arbiter #(.N_REQ(N), .X_W(XW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [15:0] x;
    int          addr;
    int          y;
  } vec_t;

  vec_t vecs [8];
  int   total = 0;
  int   bad   = 0;
  int   ey [4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_rr_operands();
    req_x[0*XW +: XW] = 16'h0080;
    req_x[1*XW +: XW] = 16'hFF80;
    req_x[2*XW +: XW] = 16'h0000;
    req_x[3*XW +: XW] = 16'h0100;
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      real v;
      int  iv;
      v  = 256.0 / (1.0 + $exp(-a / 16.0));
      iv = $rtoi(v + 0.5);
      if (iv > 255) iv = 255;
      rom_tbl[a] = 16'(iv);
    end
    vecs[0] = '{0, 16'h0080,  8, 159};
    vecs[1] = '{2, 16'hFF80,  8,  97};
    vecs[2] = '{1, 16'h7FFF, 96, 255};
    vecs[3] = '{3, 16'h8000, 96,   1};
    vecs[4] = '{0, 16'h0610, 96, 255};
    vecs[5] = '{1, 16'h0000,  0, 128};
    vecs[6] = '{3, 16'h0100, 16, 187};
    vecs[7] = '{2, 16'hFF00, 16,  69};
    ey = '{159, 97, 128, 187};

    // Reset state with every requester asking.
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    req_x      = '0;
    set_rr_operands();
    repeat (2) settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_rom_addr", rom_addr, 0);

    // Round robin with all four valid.
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      settle();
      chk("rr_grant", req_ready, 1 << (k % 4));
      if (k >= 2) begin
        chk("rr_resp_valid", resp_valid, 1);
        chk("rr_resp_id", resp_id, (k - 2) % 4);
        chk("rr_resp_y", resp_y, ey[(k - 2) % 4]);
      end else begin
        chk("rr_resp_valid_early", resp_valid, 0);
      end
    end
    step(); req_valid = 4'h0; settle();
    chk("rr_tail_id2", resp_id, 2);
    chk("rr_tail_y2", resp_y, 128);
    step(); settle();
    chk("rr_tail_id3", resp_id, 3);
    chk("rr_tail_y3", resp_y, 187);
    step(); settle();
    chk("rr_drained", resp_valid, 0);

    // Backpressure: two results in flight, consumer stalls for three cycles.
    step();
    req_valid = 4'b0001; req_x[0*XW +: XW] = 16'h0080;
    settle(); chk("st_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010; req_x[1*XW +: XW] = 16'h0100;
    settle(); chk("st_grant1", req_ready, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      step();
      req_valid = 4'b0100; req_x[2*XW +: XW] = 16'h0000; resp_ready = 1'b0;
      settle();
      chk("st_no_grant", req_ready, 0);
      chk("st_valid_held", resp_valid, 1);
      chk("st_id_held", resp_id, 0);
      chk("st_y_held", resp_y, 159);
      chk("st_addr_held", rom_addr, 16);
    end
    step(); resp_ready = 1'b1; req_valid = 4'b0000; settle();
    chk("st_rel_id0", resp_id, 0);
    chk("st_rel_valid0", resp_valid, 1);
    step(); settle();
    chk("st_rel_valid1", resp_valid, 1);
    chk("st_rel_id1", resp_id, 1);
    chk("st_rel_y1", resp_y, 187);
    step(); settle();
    chk("st_drained", resp_valid, 0);

    // Reset with results in flight; pointer would otherwise favour requester 2.
    step();
    req_valid = 4'b0100; req_x[2*XW +: XW] = 16'h0080;
    settle(); chk("rs_grant2", req_ready, 4'b0100);
    step();
    req_valid = 4'b0010; req_x[1*XW +: XW] = 16'h0100;
    settle(); chk("rs_grant1", req_ready, 4'b0010);
    step(); req_valid = 4'b0000; settle();
    chk("rs_pre_valid", resp_valid, 1);
    chk("rs_pre_id", resp_id, 2);
    #1 rst_n = 1'b0; req_valid = 4'hF;
    #1;
    chk("rs_valid_cleared", resp_valid, 0);
    chk("rs_y_cleared", resp_y, 0);
    chk("rs_addr_cleared", rom_addr, 0);
    chk("rs_no_grant", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; set_rr_operands();
    settle(); chk("rs_first_grant", req_ready, 4'b0001);
    step(); settle();
    chk("rs_second_grant", req_ready, 4'b0010);
    chk("rs_no_resp_yet", resp_valid, 0);
    step(); settle();
    chk("rs_third_grant", req_ready, 4'b0100);
    chk("rs_resp_id0", resp_id, 0);
    chk("rs_resp_y0", resp_y, 159);
    step(); req_valid = 4'b0000; settle();
    chk("rs_resp_id1", resp_id, 1);
    chk("rs_resp_y1", resp_y, 97);
    step(); settle();
    chk("rs_resp_id2", resp_id, 2);
    step(); settle();
    chk("rs_drained", resp_valid, 0);

    // Single-lookup vectors.
    for (int v = 0; v < 8; v++) begin
      step();
      req_valid = 4'(1 << vecs[v].req);
      req_x[vecs[v].req*XW +: XW] = vecs[v].x;
      settle();
      chk("vec_grant", req_ready, 1 << vecs[v].req);
      step(); req_valid = 4'b0000; settle();
      chk("vec_rom_addr", rom_addr, vecs[v].addr);
      chk("vec_resp_early", resp_valid, 0);
      step(); settle();
      chk("vec_resp_valid", resp_valid, 1);
      chk("vec_resp_id", resp_id, vecs[v].req);
      chk("vec_resp_y", resp_y, vecs[v].y);
      step(); settle();
      chk("vec_resp_done", resp_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
